wb_stage: RTL and testbench

- Writeback stage of the five-stage MIPS pipeline.
- Registers the M-stage results into the W-stage pipeline register.
- Extracts and extends load data by opcode and byte offset, selects the final result, and drives the register-file write port (write enable, address, data).
- Also keeps a retired-instruction counter for bench and debug use.

---
 rtl/wb_stage.sv | 140 ++++++++++++++
 tb/tb_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage MIPS pipeline.
//
// It registers the M-stage results into the W pipeline register. From the W
// fields it extracts and extends load data, selects the final result and drives
// the register-file write port. It also counts retired (non-bubble)
// instructions.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   flushM                turn this cycle's M->W transfer into a bubble
//   instrM, pcM           M-stage instruction word and PC
//   aluoutM               ALU result (low 2 bits are the load byte offset)
//   dmrdataM              raw aligned word read from data memory
//   regwriteM, regaddrM   M-stage GPR write request and destination
//   wbselM                result select: 0 ALU, 1 memory, 2 PC+8, 3 as 0
//   RegWrite/Addr/Data    GPR write port
//   instrW, pcW           W-stage instruction and PC
//   retired               count of non-bubble instructions that reached W
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flushM,
  input  logic [31:0]      instrM,
  input  logic [31:0]      pcM,
  input  logic [31:0]      aluoutM,
  input  logic [31:0]      dmrdataM,
  input  logic             regwriteM,
  input  logic [4:0]       regaddrM,
  input  logic [1:0]       wbselM,
  output logic             RegWrite,
  output logic [4:0]       RegAddr,
  output logic [31:0]      RegData,
  output logic [31:0]      instrW,
  output logic [31:0]      pcW,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;

  logic [31:0] aluoutW;
  logic [31:0] dmrdataW;
  logic        regwriteW;
  logic [4:0]  regaddrW;
  logic [1:0]  wbselW;

  // W pipeline register. No stall: W always loads. A flush keeps the PC so
  // the bubble still carries a meaningful pcW.
  always_ff @(posedge clk) begin
    if (reset) begin
      instrW    <= '0;
      pcW       <= PC_RESET;
      aluoutW   <= '0;
      dmrdataW  <= '0;
      regwriteW <= 1'b0;
      regaddrW  <= '0;
      wbselW    <= '0;
    end else if (flushM) begin
      instrW    <= '0;
      pcW       <= pcM;
      aluoutW   <= '0;
      dmrdataW  <= '0;
      regwriteW <= 1'b0;
      regaddrW  <= '0;
      wbselW    <= '0;
    end else begin
      instrW    <= instrM;
      pcW       <= pcM;
      aluoutW   <= aluoutM;
      dmrdataW  <= dmrdataM;
      regwriteW <= regwriteM;
      regaddrW  <= regaddrM;
      wbselW    <= wbselM;
    end
  end

  // Retired counter: counts captured instructions that are neither bubbles
  // nor all-zero nops. Wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (!flushM && (instrM != 32'd0)) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Load extraction from the W fields.
  logic [5:0]  opW;
  logic [1:0]  offW;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  assign opW  = instrW[31:26];
  assign offW = aluoutW[1:0];

  always_comb begin
    byteSel = dmrdataW[7:0];
    unique case (offW)
      2'd0: byteSel = dmrdataW[7:0];
      2'd1: byteSel = dmrdataW[15:8];
      2'd2: byteSel = dmrdataW[23:16];
      2'd3: byteSel = dmrdataW[31:24];
      default: byteSel = dmrdataW[7:0];
    endcase
    // Halfword loads ignore offset bit 0.
    halfSel = offW[1] ? dmrdataW[31:16] : dmrdataW[15:0];

    loadData = dmrdataW;
    case (opW)
      OpLb:    loadData = {{24{byteSel[7]}}, byteSel};
      OpLbu:   loadData = {24'd0, byteSel};
      OpLh:    loadData = {{16{halfSel[15]}}, halfSel};
      OpLhu:   loadData = {16'd0, halfSel};
      OpLw:    loadData = dmrdataW;
      default: loadData = dmrdataW;
    endcase
  end

  // Result select and write port. RegData is driven even when no write.
  always_comb begin
    RegData = aluoutW;
    case (wbselW)
      2'd1:    RegData = loadData;
      2'd2:    RegData = pcW + 32'd8;
      default: RegData = aluoutW;
    endcase
  end

  // Writes to $0 are suppressed here so the register file never sees them.
  assign RegWrite = regwriteW && (regaddrW != 5'd0);
  assign RegAddr  = regaddrW;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Expected W outputs are pushed to a
// scoreboard when a transaction is driven and popped one cycle later.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flushM;
  logic [31:0] instrM, pcM, aluoutM, dmrdataM;
  logic        regwriteM;
  logic [4:0]  regaddrM;
  logic [1:0]  wbselM;
  logic        RegWrite;
  logic [4:0]  RegAddr;
  logic [31:0] RegData, instrW, pcW, retired;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] iw;
    logic [31:0] pw;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] expRetired = 32'd0;

  wb_stage #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .flushM   (flushM),
    .instrM   (instrM),
    .pcM      (pcM),
    .aluoutM  (aluoutM),
    .dmrdataM (dmrdataM),
    .regwriteM(regwriteM),
    .regaddrM (regaddrM),
    .wbselM   (wbselM),
    .RegWrite (RegWrite),
    .RegAddr  (RegAddr),
    .RegData  (RegData),
    .instrW   (instrW),
    .pcW      (pcW),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Drive one M-stage transaction (not in reset) and push what W must show.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] dmr,
                      input logic rw, input logic [4:0] ra, input logic [1:0] ws,
                      input logic flush, input logic [31:0] expData);
    exp_t e;
    reset = 1'b0; flushM = flush; instrM = instr; pcM = pc; aluoutM = alu;
    dmrdataM = dmr; regwriteM = rw; regaddrM = ra; wbselM = ws;
    if (!flush && instr != 32'd0) expRetired = expRetired + 32'd1;
    e.rw  = !flush && rw && (ra != 5'd0);
    e.ra  = flush ? 5'd0 : ra;
    e.rd  = expData;
    e.iw  = flush ? 32'd0 : instr;
    e.pw  = pc;
    e.ret = expRetired;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1; flushM = 1'b0; instrM = '0; pcM = '0; aluoutM = '0;
    dmrdataM = '0; regwriteM = 1'b0; regaddrM = '0; wbselM = '0;
    expRetired = 32'd0;
    e = '{rw: 1'b0, ra: 5'd0, rd: 32'd0, iw: 32'd0, pw: 32'h0000_3000, ret: 32'd0};
    sb.push_back(e);
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'd0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
          || pcW !== e.pw || retired !== e.ret) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
                 i, RegWrite, RegAddr, RegData, instrW, pcW, retired,
                 e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
      end
      if (i < 3) begin
        // Inputs for the next idle cycle are already queued; apply them in order.
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_alu_write;
    exp_t e;
    logic [31:0] instr [4] = '{32'h0022_1820, 32'h0022_1820, 32'h0064_2821, 32'h0000_0000};
    logic [31:0] alu   [4] = '{32'h5, 32'h1234, 32'hDEAD_BEEF, 32'h77};
    logic [4:0]  ra    [4] = '{5'd3, 5'd0, 5'd5, 5'd6};
    logic [1:0]  ws    [4] = '{2'd0, 2'd0, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send(instr[i], 32'h0000_3004 + 32'(4 * i), alu[i], 32'hAAAA_5555, 1'b1, ra[i], ws[i],
           1'b0, alu[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
          || pcW !== e.pw || retired !== e.ret) begin
        failures++;
        $display("FAIL alu_write[%0d]: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
                 i, RegWrite, RegAddr, RegData, instrW, pcW, retired,
                 e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
      end
    end
  endtask

  task automatic test_loads;
    exp_t e;
    logic [5:0]  op  [10] = '{6'h20, 6'h24, 6'h21, 6'h21, 6'h25, 6'h23, 6'h23, 6'h24,
                              6'h20, 6'h0F};
    logic [1:0]  off [10] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd1};
    logic [31:0] exv [10] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_007F,
                              32'h0000_0001, 32'h80FF_7F01};
    for (int i = 0; i < 10; i++) begin
      send({op[i], 5'd1, 5'd4, 16'h0010}, 32'h0000_3100 + 32'(4 * i),
           {30'h0400_0004, off[i]}, 32'h80FF_7F01, 1'b1, 5'd4, 2'd1, 1'b0, exv[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
          || pcW !== e.pw || retired !== e.ret) begin
        failures++;
        $display("FAIL load[%0d] op=%h off=%0d: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
                 i, op[i], off[i], RegWrite, RegAddr, RegData, instrW, pcW, retired,
                 e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
      end
    end
  endtask

  task automatic test_jal_link;
    exp_t e;
    logic [31:0] pc [2] = '{32'h0000_3010, 32'hFFFF_FFFC};
    logic [31:0] ex [2] = '{32'h0000_3018, 32'h0000_0004};
    for (int i = 0; i < 2; i++) begin
      send(32'h0C00_0C10, pc[i], 32'h1111_2222, 32'h0, 1'b1, 5'd31, 2'd2, 1'b0, ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
          || pcW !== e.pw || retired !== e.ret) begin
        failures++;
        $display("FAIL jal_link[%0d]: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
                 i, RegWrite, RegAddr, RegData, instrW, pcW, retired,
                 e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
      end
    end
  endtask

  task automatic test_flush;
    exp_t e;
    // Valid ALU write flushed, then a load flushed, then a normal write after.
    send(32'h0022_1820, 32'h0000_3200, 32'h99, 32'h0, 1'b1, 5'd3, 2'd0, 1'b1, 32'd0);
    @(posedge clk); #1;
    send(32'h8C24_0000, 32'h0000_3204, 32'h4, 32'h1234_5678, 1'b1, 5'd4, 2'd1, 1'b1, 32'd0);
    @(posedge clk); #1;
    send(32'h0022_1820, 32'h0000_3208, 32'h42, 32'h0, 1'b1, 5'd7, 2'd0, 1'b0, 32'h42);
    @(posedge clk); #1;
    // Only one transaction is in W at a time, so just the newest entry is live.
    while (sb.size() > 1) begin
      e = sb.pop_front();
    end
    e = sb.pop_front();
    checks++;
    if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
        || pcW !== e.pw || retired !== e.ret) begin
      failures++;
      $display("FAIL after_flush: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
               RegWrite, RegAddr, RegData, instrW, pcW, retired,
               e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
    end
    for (int i = 0; i < 2; i++) begin
      send(32'h8C24_0000 + 32'(i), 32'h0000_3300 + 32'(4 * i), 32'h8, 32'hCAFE_F00D, 1'b1,
           5'd9, 2'(i + 1), 1'b1, 32'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
          || pcW !== e.pw || retired !== e.ret) begin
        failures++;
        $display("FAIL flush[%0d]: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
                 i, RegWrite, RegAddr, RegData, instrW, pcW, retired,
                 e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    send(32'h0022_1820, 32'h0000_3400, 32'h55, 32'h0, 1'b1, 5'd3, 2'd0, 1'b0, 32'h55);
    @(posedge clk); #1;
    void'(sb.pop_front());
    // Valid write presented together with reset, then with reset and flush.
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1; flushM = 1'(i); instrM = 32'h0022_1820; pcM = 32'h0000_3404;
      aluoutM = 32'h66; regwriteM = 1'b1; regaddrM = 5'd3; wbselM = 2'd2;
      expRetired = 32'd0;
      e = '{rw: 1'b0, ra: 5'd0, rd: 32'd0, iw: 32'd0, pw: 32'h0000_3000, ret: 32'd0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
          || pcW !== e.pw || retired !== e.ret) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
                 i, RegWrite, RegAddr, RegData, instrW, pcW, retired,
                 e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
      end
    end
    // Counting resumes from zero.
    send(32'h0022_1820, 32'h0000_3408, 32'h77, 32'h0, 1'b1, 5'd8, 2'd0, 1'b0, 32'h77);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (RegWrite !== e.rw || RegAddr !== e.ra || RegData !== e.rd || instrW !== e.iw
        || pcW !== e.pw || retired !== e.ret) begin
      failures++;
      $display("FAIL reset_resume: got we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d want we=%b ad=%0d d=%h iw=%h pc=%h ret=%0d",
               RegWrite, RegAddr, RegData, instrW, pcW, retired,
               e.rw, e.ra, e.rd, e.iw, e.pw, e.ret);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_jal_link();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
